// File: rtl/mux_select_arbiter_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared constants and state type for the mux select arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    // Requester count and owner-index width of the shared 8:1 mux
    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    // Default hold limit used when grant revocation is built in
    localparam int MAX_HOLD_DEFAULT = 16;

    // Arbiter state
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage : arb_pkg

`default_nettype wire

// File: rtl/mux_select_arbiter_rr_pick8.sv
// ============================================================================
// Module      : rr_pick8
// Description : Combinational rotate-priority picker. Scans the requests that
//               are not excluded, starting at ptr and ascending with wrap
//               7->0; the first set bit wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_REQ-1:0] exclude,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] w_cand;
    logic [SEL_W-1:0] w_scan;

    assign w_cand = req & ~exclude;

    // First eligible requester at or after ptr, wrapping around
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_scan = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = ptr + SEL_W'(k);
            if (!found && w_cand[w_scan]) begin
                found = 1'b1;
                idx   = w_scan;
            end
        end
    end

endmodule : rr_pick8

`default_nettype wire

// File: rtl/mux_select_arbiter.sv
// ============================================================================
// Module      : mux_select_arbiter
// Description : Round-robin arbiter sharing one 8:1 mux among 8 requesters.
//               The owner keeps the mux until it drops its request; a release
//               re-arbitrates on the same edge with no idle bubble.
//               Build option ARB_TIMEOUT_EN adds a hold counter that revokes a
//               grant after MAX_HOLD cycles and pulses timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_select_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic             select2,
    output logic             select1,
    output logic             select0,
    output logic             timeout
);

    // Elaboration-time guard on the hold limit
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux_select_arbiter: MAX_HOLD out of range 2..255");
    end

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [SEL_W-1:0] r_owner;
    logic [SEL_W-1:0] w_owner_nxt;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] w_grant_nxt;
    logic             r_grant_valid;
    logic             w_valid_nxt;

    logic             w_release;
    logic             w_revoke;
    logic             w_arb;
    logic [N_REQ-1:0] w_exclude;
    logic             w_found;
    logic [SEL_W-1:0] w_pick_idx;

    assign w_release = (r_state == GRANT) && !req[r_owner];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hold;
    logic       r_timeout;

    // Owner still requesting after MAX_HOLD granted cycles loses the mux
    assign w_revoke  = (r_state == GRANT) && req[r_owner] &&
                       (r_hold == 8'(MAX_HOLD - 1));
    // Revoked owner sits out the pick that immediately follows
    assign w_exclude = w_revoke ? (N_REQ'(1) << r_owner) : '0;

    // Hold counter: cleared by every arbitration, counts cycles held in GRANT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_revoke;
            if (w_arb) begin
                r_hold <= '0;
            end else if (r_state == GRANT) begin
                r_hold <= r_hold + 8'd1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_revoke  = 1'b0;
    assign w_exclude = '0;
    assign timeout   = 1'b0;
`endif

    rr_pick8 u_pick (
        .req     (req),
        .ptr     (r_ptr),
        .exclude (w_exclude),
        .found   (w_found),
        .idx     (w_pick_idx)
    );

    // Next-state: arbitrate from IDLE on any request, or from GRANT on release/revoke
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_grant_nxt = r_grant;
        w_valid_nxt = r_grant_valid;
        w_arb       = 1'b0;

        case (r_state)
            IDLE:    w_arb = |req;
            GRANT:   w_arb = w_release || w_revoke;
            default: w_arb = 1'b0;
        endcase

        if (w_arb) begin
            if (w_found) begin
                w_state_nxt = GRANT;
                w_owner_nxt = w_pick_idx;
                w_ptr_nxt   = w_pick_idx + SEL_W'(1);
                w_grant_nxt = N_REQ'(1) << w_pick_idx;
                w_valid_nxt = 1'b1;
            end else begin
                // Nobody else waiting: selects keep the last owner value
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
            end
        end
    end

    // State, pointer, owner and grant registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_owner       <= w_owner_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= w_valid_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign select2     = r_owner[2];
    assign select1     = r_owner[1];
    assign select0     = r_owner[0];

endmodule : mux_select_arbiter

`default_nettype wire

// File: tb/tb_mux_select_arbiter.sv
// ============================================================================
// Module      : tb_mux_select_arbiter
// Description : Directed self-checking bench for mux_select_arbiter.
//               Timeout scenario is selected by ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_select_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] grant;
    logic       grant_valid;
    logic       select2;
    logic       select1;
    logic       select0;
    logic       timeout;

    int n_checks;
    int n_fails;

    mux_select_arbiter #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .select2     (select2),
        .select1     (select1),
        .select0     (select0),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge, then verify the grant/valid invariant
    task automatic tick();
        @(posedge clk);
        #1;
        chk("valid_eq_or_grant", {7'd0, grant_valid}, {7'd0, |grant});
    endtask

    task automatic chk_grant(input string tag, input logic [7:0] exp_g, input logic [2:0] exp_sel);
        chk(tag, grant, exp_g);
        chk({tag, "_valid"}, {7'd0, grant_valid}, {7'd0, exp_g != 8'h00});
        chk({tag, "_sel"}, {5'd0, select2, select1, select0}, {5'd0, exp_sel});
    endtask

    logic [7:0] exp_g;
    logic [7:0] prev_g;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        req      = 8'hFF;

        // Reset held 2 cycles with every requester active
        tick();
        chk_grant("rst_c1", 8'h00, 3'd0);
        chk("rst_c1_to", {7'd0, timeout}, 8'h00);
        tick();
        chk_grant("rst_c2", 8'h00, 3'd0);
        reset = 1'b0;
        tick();
        chk_grant("first_grant", 8'h01, 3'd0);
        req = 8'h00;
        tick();
        chk_grant("release_idle", 8'h00, 3'd0);

        // Single request from requester 5
        req = 8'h20;
        tick();
        chk_grant("single", 8'h20, 3'd5);
        req = 8'h00;
        tick();
        chk_grant("single_drop", 8'h00, 3'd5);

        // Fair rotation: each owner drops for one cycle then re-raises
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 8'hFF;
        tick();
        chk_grant("rot_0", 8'h01, 3'd0);
        prev_g = 8'h01;
        for (int i = 1; i <= 8; i++) begin
            req = 8'hFF & ~prev_g;
            tick();
            exp_g = 8'h01 << (i % 8);
            chk_grant($sformatf("rot_%0d", i), exp_g, 3'(i % 8));
            prev_g = exp_g;
        end
        req = 8'h00;
        tick();
        chk_grant("rot_end", 8'h00, 3'd0);

        // No preemption: owner 3 keeps the mux while requester 0 waits
        req = 8'h08;
        tick();
        chk_grant("np_own", 8'h08, 3'd3);
        req = 8'h09;
        tick();
        chk_grant("np_hold1", 8'h08, 3'd3);
        tick();
        chk_grant("np_hold2", 8'h08, 3'd3);
        req = 8'h01;
        tick();
        chk_grant("np_handoff", 8'h01, 3'd0);
        req = 8'h00;
        tick();
        chk_grant("np_idle", 8'h00, 3'd0);

        // Mid-grant reset, then pointer must be back at 0
        req = 8'h40;
        tick();
        chk_grant("mr_own", 8'h40, 3'd6);
        reset = 1'b1;
        tick();
        chk_grant("mr_rst", 8'h00, 3'd0);
        reset = 1'b0;
        req = 8'hC0;
        tick();
        chk_grant("mr_ptr0", 8'h40, 3'd6);
        req = 8'h00;
        tick();
        chk_grant("mr_idle", 8'h00, 3'd6);

        // Hold limit behaviour with two constant requesters
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 8'h03;
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c <= 4)      exp_g = 8'h01;
            else if (c <= 8) exp_g = 8'h02;
            else             exp_g = 8'h01;
            chk($sformatf("to_grant_c%0d", c), grant, exp_g);
            chk($sformatf("to_pulse_c%0d", c), {7'd0, timeout},
                {7'd0, (c == 5) || (c == 9)});
        end
`else
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("hold_grant_c%0d", c), grant, 8'h01);
            chk($sformatf("hold_to_c%0d", c), {7'd0, timeout}, 8'h00);
        end
`endif
        req = 8'h00;
        tick();
        chk("final_idle", grant, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule : tb_mux_select_arbiter

`default_nettype wire

// File: doc/mux_select_arbiter.md
Name: mux_select_arbiter

Overview:
- Round-robin arbiter that shares one 8-input mux_8x1 datapath among 8 requesters.
- Drives the mux select lines and a one-hot grant.
- The granted requester owns the mux until it drops its request.
- Sits between requester units (e.g. register-read or bus sources) and the shared 8:1 mux feeding a common 32-bit consumer.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request vector; req[i] selects mux_input(i+1).
- grant  output  8  one-hot grant, all zero when idle; registered.
- grant_valid  output  1  high when any grant is active; registered.
- select2  output  1  mux select MSB (owner index bit 2).
- select1  output  1  owner index bit 1.
- select0  output  1  owner index bit 0.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. On reset, at the clock edge and with priority over all other events:
  - state=IDLE, grant=0, grant_valid=0, select2..0=0, timeout=0.
  - Round-robin pointer ptr=0, hold counter=0.
- Reset mid-grant drops the grant on that same edge; no release handshake.
- Select encoding: {select2,select1,select0} = binary index of the owner. Selects hold their last owner value while in IDLE; downstream must qualify with grant_valid.
- Pick function: scan req starting at index ptr, ascending, wrapping 7->0. The first set bit wins.
- State IDLE:
  - If req!=0 at an edge: grant the winner and go to GRANT.
  - Grant is visible one cycle after req is sampled (latency 1).
  - ptr <= winner+1 mod 8.
- State GRANT, owner o:
  - req[o]=1: hold grant, selects and ptr.
  - req[o]=0 with other requests pending: re-arbitrate on the same edge with no idle bubble. Update grant, selects and ptr; state stays GRANT.
  - req[o]=0 with no requests: go to IDLE, grant=0, grant_valid=0.
- Requests from non-owners never preempt the owner.
- A requester that drops and re-raises req in the same cycle as its release is treated as a new request, at lowest priority (ptr has moved past it).
- Simultaneous requests from all 8: granted in order ptr, ptr+1, ... across successive releases. Every requester is served within 7 grants (starvation-free).
- Invariant: grant is one-hot or zero, and grant_valid == |grant.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter increments each cycle in GRANT and clears on every new grant.
  - When the owner has held for MAX_HOLD cycles while still requesting, the grant is revoked at that edge and timeout pulses for 1 cycle.
  - Arbitration then proceeds exactly as for a release, but the revoked owner is excluded for that pick only.
  - If no other request is pending, go to IDLE. The revoked requester may win again on the next arbitration.
- Undefined: no counter is built, timeout is tied 0, and an owner may hold indefinitely.

Decomposition:
- Package arb_pkg holds:
  - N_REQ=8 and SEL_W=3.
  - The state enum {IDLE, GRANT}.
  - The default MAX_HOLD constant.
- One sub-module, rr_pick8: combinational rotate-priority picker.
  - Inputs: req[7:0], ptr[2:0], exclude[7:0].
  - Outputs: found, idx[2:0].
- Top-level block: state register, ptr, grant/select registers, optional hold counter.

Test Plan:
- Reset behaviour: reset=1 for 2 cycles with req=8'hFF -> grant=0, grant_valid=0, selects=000 throughout. First grant after reset deassert is grant=8'h01.
- Single request: req=8'h20 -> next cycle grant=8'h20, select2..0=101, grant_valid=1. Drop req -> following cycle grant=0, grant_valid=0.
- Fair rotation: req=8'hFF held, each owner drops and re-raises req after 1 cycle of grant -> grant sequence 01,02,04,...,80,01 with no idle cycles.
- No preemption: owner 3 holds, then req[0] rises -> grant stays 8'h08 until req[3] falls, then 8'h01 on the same edge.
- Mid-grant reset: owner 6 granted, reset pulsed 1 cycle -> grant=0 the next cycle. Re-arbitration starts from ptr=0.
- ARB_TIMEOUT_EN with MAX_HOLD=4: req=8'h03 held constantly -> grant 01 for 4 cycles, then timeout pulse and grant 02 for 4 cycles, then timeout and grant 01. Without the macro, grant stays 01 and timeout=0.
